// File: rtl/dma_bus_arbiter_pkg.sv
// Shared definitions for the DMA bus arbiter: widths, burst length, FSM states.
// Imported by dma_bus_arbiter and dma_irq_latch.
package dma_defs;

  localparam int DMA_WORD_SIZE     = 16;
  localparam int DMA_BURST_LEN     = 12;
  localparam int DMA_GRANT_TIMEOUT = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BR,
    ST_WAIT_CPU,
    ST_GRANT,
    ST_DONE
  } state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dma_irq_latch.sv
// Sticky interrupt flag: set has priority over ack, async active-low reset.
// Shared by the arbiter top for the DMA completion interrupt.
module dma_irq_latch
  import dma_defs::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic set,
  input  logic ack,
  output logic flag
);

  logic flag_q;
  logic flag_d;

  // next flag: set wins, ack clears, otherwise hold
  always_comb begin
    flag_d = flag_q;
    if (set) begin
      flag_d = 1'b1;
    end else if (ack) begin
      flag_d = 1'b0;
    end
  end

  // flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/dma_bus_arbiter.sv
// DMA bus arbiter: takes CPU commands, kicks the DMA engine, owns BR/BG and the memory mux.
// Optional grant watchdog enabled by defining DMA_ARB_TIMEOUT_EN.
module dma_bus_arbiter
  import dma_defs::*;
#(
  parameter int WORD_SIZE     = DMA_WORD_SIZE,
  parameter int BURST_LEN     = DMA_BURST_LEN,
  parameter int GRANT_TIMEOUT = DMA_GRANT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_cmd_valid,
  input  logic [WORD_SIZE-1:0] cpu_cmd_addr,
  output logic                 cpu_cmd_ready,
  input  logic                 cpu_mem_busy,
  input  logic [WORD_SIZE-1:0] cpu_addr,
  input  logic                 cpu_write,
  output logic                 cpu_stall,
  output logic                 dma_length,
  output logic [WORD_SIZE-1:0] dma_address,
  input  logic                 dma_br,
  output logic                 dma_bg,
  input  logic                 dma_use_bus,
  input  logic                 dma_write,
  input  logic [WORD_SIZE-1:0] dma_wr_addr,
  input  logic                 dma_irq,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic                 mem_write,
  output logic                 irq_out,
  input  logic                 irq_ack,
  output logic [7:0]           xfer_count,
  output logic                 err
);

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [7:0]           xfer_q, xfer_d;
  logic                 err_q, err_d;
  logic                 mem_sel;

`ifdef DMA_ARB_TIMEOUT_EN
  localparam int TW = $clog2(GRANT_TIMEOUT + 1);
  logic [TW-1:0] gcnt_q, gcnt_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = GRANT_TIMEOUT;
`endif

  // next state, latched address, word count and error flag
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    xfer_d  = xfer_q;
    err_d   = err_q;
`ifdef DMA_ARB_TIMEOUT_EN
    gcnt_d  = gcnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_cmd_valid) begin
          addr_d  = cpu_cmd_addr;
          xfer_d  = 8'd0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BR;
      end
      ST_WAIT_BR: begin
        if (dma_br) begin
          state_d = ST_WAIT_CPU;
        end
      end
      ST_WAIT_CPU: begin
`ifdef DMA_ARB_TIMEOUT_EN
        gcnt_d = '0;
`endif
        if (!cpu_mem_busy) begin
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (dma_write && dma_use_bus) begin
          xfer_d = sat_inc(xfer_q);
        end
        if (!dma_br) begin
          state_d = ST_DONE;
        end
`ifdef DMA_ARB_TIMEOUT_EN
        gcnt_d = gcnt_q + 1'b1;
        if (gcnt_q == TW'(GRANT_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        if (xfer_q != 8'(BURST_LEN)) begin
          err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      xfer_q  <= 8'd0;
      err_q   <= 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
      gcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      xfer_q  <= xfer_d;
      err_q   <= err_d;
`ifdef DMA_ARB_TIMEOUT_EN
      gcnt_q  <= gcnt_d;
`endif
    end
  end

  // state-decoded handshakes; BG and mux select follow GRANT directly
  always_comb begin
    cpu_cmd_ready = (state_q == ST_IDLE);
    dma_length    = (state_q == ST_ISSUE);
    cpu_stall     = (state_q == ST_WAIT_BR)
                 || (state_q == ST_WAIT_CPU)
                 || (state_q == ST_GRANT);
    dma_bg        = (state_q == ST_GRANT);
    mem_sel       = (state_q == ST_GRANT);
  end

  // memory port mux
  always_comb begin
    mem_addr  = mem_sel ? dma_wr_addr : cpu_addr;
    mem_write = mem_sel ? dma_write : cpu_write;
  end

  dma_irq_latch u_irq (
    .clk     (clk),
    .reset_n (reset_n),
    .set     (dma_irq),
    .ack     (irq_ack),
    .flag    (irq_out)
  );

  assign dma_address = addr_q;
  assign xfer_count  = xfer_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Randomized self-checking bench for dma_bus_arbiter with a transaction-level model.
// Define DMA_ARB_TIMEOUT_EN for both RTL and bench to exercise the grant watchdog.
module tb_dma_bus_arbiter;

  localparam int W  = 16;
  localparam int BL = 12;
  localparam int GT = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cpu_cmd_valid;
  logic [W-1:0] cpu_cmd_addr;
  logic         cpu_cmd_ready;
  logic         cpu_mem_busy;
  logic [W-1:0] cpu_addr;
  logic         cpu_write;
  logic         cpu_stall;
  logic         dma_length;
  logic [W-1:0] dma_address;
  logic         dma_br;
  logic         dma_bg;
  logic         dma_use_bus;
  logic         dma_write;
  logic [W-1:0] dma_wr_addr;
  logic         dma_irq;
  logic [W-1:0] mem_addr;
  logic         mem_write;
  logic         irq_out;
  logic         irq_ack;
  logic [7:0]   xfer_count;
  logic         err;

  always #5 clk = ~clk;

  dma_bus_arbiter #(
    .WORD_SIZE     (W),
    .BURST_LEN     (BL),
    .GRANT_TIMEOUT (GT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_cmd_valid (cpu_cmd_valid),
    .cpu_cmd_addr  (cpu_cmd_addr),
    .cpu_cmd_ready (cpu_cmd_ready),
    .cpu_mem_busy  (cpu_mem_busy),
    .cpu_addr      (cpu_addr),
    .cpu_write     (cpu_write),
    .cpu_stall     (cpu_stall),
    .dma_length    (dma_length),
    .dma_address   (dma_address),
    .dma_br        (dma_br),
    .dma_bg        (dma_bg),
    .dma_use_bus   (dma_use_bus),
    .dma_write     (dma_write),
    .dma_wr_addr   (dma_wr_addr),
    .dma_irq       (dma_irq),
    .mem_addr      (mem_addr),
    .mem_write     (mem_write),
    .irq_out       (irq_out),
    .irq_ack       (irq_ack),
    .xfer_count    (xfer_count),
    .err           (err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit irq_m   = 1'b0;
  bit err_m   = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; the irq model sees the inputs present at the edge
  task automatic step();
    if (dma_irq) irq_m = 1'b1;
    else if (irq_ack) irq_m = 1'b0;
    @(posedge clk);
    #1;
    dma_irq = 1'b0;
    irq_ack = 1'b0;
    check("irq_out", irq_out, irq_m);
  endtask

  // one full command; abort resets mid-grant, hold keeps br high
  task automatic run_burst(input logic [W-1:0] addr,
                           input int busy,
                           input int br_dly,
                           input int grant_cyc,
                           input bit all_wr,
                           input bit irq_end,
                           input bit abort,
                           input bit hold);
    int wcount;
    int gcnt;
    wcount = 0;
    gcnt   = 0;
    check("cmd_ready_idle", cpu_cmd_ready, 1);
    cpu_cmd_valid = 1'b1;
    cpu_cmd_addr  = addr;
    step();
    check("dma_length_pulse", dma_length, 1);
    check("dma_address", dma_address, addr);
    check("cmd_ready_busy", cpu_cmd_ready, 0);
    cpu_cmd_addr = ~addr;
    step();
    check("dma_length_once", dma_length, 0);
    check("stall_wait_br", cpu_stall, 1);
    repeat (br_dly) begin
      check("bg_wait_br", dma_bg, 0);
      step();
    end
    dma_br       = 1'b1;
    cpu_mem_busy = (busy > 0);
    step();
    for (int k = 0; k < busy; k++) begin
      check("bg_while_busy", dma_bg, 0);
      check("stall_while_busy", cpu_stall, 1);
      step();
    end
    cpu_mem_busy = 1'b0;
    check("bg_before_grant", dma_bg, 0);
    step();
    cpu_cmd_valid = 1'b0;
    forever begin
      if (hold) begin
        if (!dma_bg || gcnt >= GT + 8) break;
      end else if (gcnt == grant_cyc) begin
        break;
      end
      dma_use_bus = all_wr ? 1'b1 : 1'($urandom);
      dma_write   = all_wr ? 1'b1 : 1'($urandom);
      dma_wr_addr = W'($urandom);
      cpu_addr    = W'($urandom);
      cpu_write   = 1'($urandom);
      #1;
      check("bg_grant", dma_bg, 1);
      check("stall_grant", cpu_stall, 1);
      check("mem_addr_dma", mem_addr, dma_wr_addr);
      check("mem_write_dma", mem_write, dma_write);
      if (dma_use_bus && dma_write) wcount++;
      step();
      gcnt++;
    end
    dma_use_bus = 1'b0;
    dma_write   = 1'b0;
    if (abort) begin
      #2 reset_n = 1'b0;
      #1;
      irq_m = 1'b0;
      err_m = 1'b0;
      dma_br = 1'b0;
      check("rst_bg", dma_bg, 0);
      check("rst_stall", cpu_stall, 0);
      check("rst_mem_sel", mem_addr, cpu_addr);
      check("rst_xfer", xfer_count, 0);
      check("rst_err", err, 0);
      check("rst_irq", irq_out, 0);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      check("rst_cmd_ready", cpu_cmd_ready, 1);
      return;
    end
    if (hold) begin
      check("timeout_cycles", gcnt, GT);
      dma_br = 1'b0;
      err_m  = 1'b1;
    end else begin
      dma_br  = 1'b0;
      dma_irq = irq_end;
      #1;
      check("bg_last_cycle", dma_bg, 1);
      step();
    end
    check("bg_done", dma_bg, 0);
    check("stall_done", cpu_stall, 0);
    check("cmd_ready_done", cpu_cmd_ready, 0);
    cpu_addr  = W'($urandom);
    cpu_write = 1'($urandom);
    #1;
    check("mem_addr_cpu", mem_addr, cpu_addr);
    check("mem_write_cpu", mem_write, cpu_write);
    check("xfer_count", xfer_count, (wcount > 255) ? 255 : wcount);
    check("dma_address_hold", dma_address, addr);
    step();
    if (wcount != BL) err_m = 1'b1;
    check("err", err, err_m);
    check("cmd_ready_back", cpu_cmd_ready, 1);
  endtask

  initial begin
    reset_n       = 1'b0;
    cpu_cmd_valid = 1'b0;
    cpu_cmd_addr  = '0;
    cpu_mem_busy  = 1'b0;
    cpu_addr      = 16'h1234;
    cpu_write     = 1'b1;
    dma_br        = 1'b0;
    dma_use_bus   = 1'b0;
    dma_write     = 1'b0;
    dma_wr_addr   = 16'hBEEF;
    dma_irq       = 1'b0;
    irq_ack       = 1'b0;
    #12;
    check("reset_ready", cpu_cmd_ready, 1);
    check("reset_stall", cpu_stall, 0);
    check("reset_bg", dma_bg, 0);
    check("reset_length", dma_length, 0);
    check("reset_address", dma_address, 0);
    check("reset_irq", irq_out, 0);
    check("reset_xfer", xfer_count, 0);
    check("reset_err", err, 0);
    check("reset_mem_addr", mem_addr, 16'h1234);
    check("reset_mem_write", mem_write, 1);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // clean 12-word burst with completion irq on br fall
    run_burst(16'h0100, 0, 1, BL, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t1_irq", irq_out, 1);
    check("t1_err", err, 0);

    // simultaneous set and ack keeps irq, lone ack clears
    dma_irq = 1'b1;
    irq_ack = 1'b1;
    step();
    check("t4_set_wins", irq_out, 1);
    irq_ack = 1'b1;
    step();
    check("t4_ack_clears", irq_out, 0);

    // cpu busy for 3 cycles in WAIT_CPU
    run_burst(16'h0200, 3, 0, BL, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_err", err, 0);

    // short burst of 5 words
    run_burst(16'h0300, 0, 2, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t3_xfer", xfer_count, 5);
    check("t3_err", err, 1);

    // randomized commands, irq and acks
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        irq_ack = 1'b1;
        dma_irq = 1'($urandom);
        step();
      end
      run_burst(W'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 2), $urandom_range(1, 20),
                ($urandom_range(0, 3) == 0), 1'($urandom),
                1'b0, 1'b0);
    end

    // reset in the middle of a grant
    run_burst(16'h0400, 1, 0, 4, 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef DMA_ARB_TIMEOUT_EN
    // br never released: watchdog ends the grant
    run_burst(16'h0500, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_err", err, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
